// File: rtl/lcd_pkg.sv
// Shared LCD definitions: controller opcodes and the command sequencer state encoding.
package lcd_pkg;

    localparam logic [3:0] CMD_WR   = 4'd0;
    localparam logic [3:0] CMD_SU   = 4'd1;
    localparam logic [3:0] CMD_SD   = 4'd2;
    localparam logic [3:0] CMD_SL   = 4'd3;
    localparam logic [3:0] CMD_SR   = 4'd4;
    localparam logic [3:0] CMD_MAX  = 4'd5;
    localparam logic [3:0] CMD_MIN  = 4'd6;
    localparam logic [3:0] CMD_AVG  = 4'd7;
    localparam logic [3:0] CMD_CCR  = 4'd8;
    localparam logic [3:0] CMD_CR   = 4'd9;
    localparam logic [3:0] CMD_MRX  = 4'd10;
    localparam logic [3:0] CMD_MRY  = 4'd11;
    localparam logic [3:0] CMD_LAST = 4'd11;

    typedef enum logic [2:0] {
        IDLE,
        ISSUE,
        WAIT_ACK,
        WAIT_DONE,
        FIN
    } seq_state_t;

endpackage

// File: rtl/cmd_fifo.sv
// Synchronous FIFO holding pending opcodes; head is the oldest entry, read without popping.
module cmd_fifo #(
    parameter int unsigned DEPTH = 8,
    parameter int unsigned WIDTH = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push,
    input  logic [WIDTH-1:0] din,
    input  logic             pop,
    output logic             full,
    output logic             empty,
    output logic [WIDTH-1:0] head
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [CNT_W-1:0] count;
    logic             do_push;
    logic             do_pop;

    assign full    = (count == CNT_W'(DEPTH));
    assign empty   = (count == '0);
    assign head    = mem[rd_ptr];
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= din;
        end
    end

    // Pointers wrap naturally since DEPTH is a power of two.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/lcd_cmd_seq.sv
// Host-to-LCD-controller command sequencer: filters illegal opcodes, buffers the rest,
// and issues them one at a time while the controller is idle, finishing after WRITE.
module lcd_cmd_seq
    import lcd_pkg::*;
#(
    parameter int unsigned DEPTH = 8
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [3:0] host_cmd,
    input  logic       host_valid,
    output logic       host_ready,
    output logic [3:0] cmd,
    output logic       cmd_valid,
    input  logic       busy,
    input  logic       done,
    output logic       seq_done,
    output logic [7:0] drop_cnt
);

    seq_state_t state;
    logic       sealed;
    logic       fifo_full;
    logic       fifo_empty;
    logic [3:0] fifo_head;
    logic       xfer;
    logic       legal;
    logic       push;
    logic       pop;

    assign host_ready = !fifo_full && !sealed;
    assign xfer       = host_valid && host_ready;
    assign legal      = (host_cmd <= CMD_LAST);
    assign push       = xfer && legal;
    assign pop        = (state == IDLE) && !fifo_empty && !busy;

    cmd_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (4)
    ) u_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (push),
        .din   (host_cmd),
        .pop   (pop),
        .full  (fifo_full),
        .empty (fifo_empty),
        .head  (fifo_head)
    );

    // Illegal opcodes are consumed but only counted; a stored WRITE closes the host port.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sealed   <= 1'b0;
            drop_cnt <= 8'd0;
        end else begin
            if (push && (host_cmd == CMD_WR)) begin
                sealed <= 1'b1;
            end
            if (xfer && !legal && (drop_cnt != 8'hFF)) begin
                drop_cnt <= drop_cnt + 8'd1;
            end
        end
    end

    // cmd is driven to 0 outside the issue cycle, since the controller decodes it unqualified.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= IDLE;
            cmd       <= 4'd0;
            cmd_valid <= 1'b0;
            seq_done  <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (pop) begin
                        cmd       <= fifo_head;
                        cmd_valid <= 1'b1;
                        state     <= ISSUE;
                    end
                end
                ISSUE: begin
                    cmd       <= 4'd0;
                    cmd_valid <= 1'b0;
                    state     <= (cmd == CMD_WR) ? WAIT_DONE : WAIT_ACK;
                end
                WAIT_ACK: begin
                    if (busy) begin
                        state <= IDLE;
                    end
                end
                WAIT_DONE: begin
                    if (done) begin
                        seq_done <= 1'b1;
                        state    <= FIN;
                    end
                end
                FIN: begin
                    state <= FIN;
                end
                default: begin
                    state     <= IDLE;
                    cmd       <= 4'd0;
                    cmd_valid <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_lcd_cmd_seq.sv
// Scoreboard bench for lcd_cmd_seq: host stimulus predicts the issue stream, a monitor
// checks every cmd_valid pulse against it, and a simple controller model answers with busy.
module tb_lcd_cmd_seq;
    import lcd_pkg::*;

    localparam int unsigned DEPTH = 8;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [3:0] host_cmd = 4'd0;
    logic       host_valid = 1'b0;
    logic       host_ready;
    logic [3:0] cmd;
    logic       cmd_valid;
    logic       busy = 1'b0;
    logic       done = 1'b0;
    logic       seq_done;
    logic [7:0] drop_cnt;

    logic       hold_busy = 1'b0;
    logic       auto_ack = 1'b1;
    logic       cv_d = 1'b0;

    int         checks = 0;
    int         errors = 0;
    int         cyc = 0;
    int         drops_m = 0;
    bit         sealed_m = 0;
    int         first_acc = -1;
    logic [3:0] exp_q[$];
    int         pulse_cyc[$];

    lcd_cmd_seq #(.DEPTH(DEPTH)) dut (
        .clk        (clk),
        .reset      (reset),
        .host_cmd   (host_cmd),
        .host_valid (host_valid),
        .host_ready (host_ready),
        .cmd        (cmd),
        .cmd_valid  (cmd_valid),
        .busy       (busy),
        .done       (done),
        .seq_done   (seq_done),
        .drop_cnt   (drop_cnt)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc++;

    // Controller model: busy for one cycle after each issue pulse, or held high on request.
    always @(negedge clk) cv_d = cmd_valid;
    always @(posedge clk) begin
        #1;
        busy = hold_busy || (auto_ack && cv_d);
    end

    task automatic chk(input string name, input int got, input int exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, got, exp, cyc);
        end
    endtask

    // Monitor: every pulse must match the oldest predicted opcode; cmd is 0 otherwise.
    always @(negedge clk) begin
        if (!reset) begin
            if (cmd_valid === 1'b1) begin
                pulse_cyc.push_back(cyc);
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_issue: got cmd %0d expected no issue (cycle %0d)", cmd, cyc);
                end else begin
                    chk("issue_order", int'(cmd), int'(exp_q.pop_front()));
                end
            end else begin
                chk("idle_cmd_zero", int'(cmd), 0);
            end
        end
    end

    // Reference model of one accepted host transfer.
    task automatic model_accept(input logic [3:0] op);
        if (sealed_m) begin
            checks++;
            errors++;
            $display("FAIL ready_after_seal: got host_ready 1 expected 0 (cycle %0d)", cyc);
        end
        if (first_acc < 0) first_acc = cyc;
        if (op > CMD_LAST) begin
            drops_m = (drops_m < 255) ? drops_m + 1 : 255;
        end else begin
            exp_q.push_back(op);
            if (op == CMD_WR) sealed_m = 1;
        end
    endtask

    task automatic offer(input logic [3:0] op, input int budget, output bit ok);
        ok = 0;
        host_cmd = op;
        host_valid = 1'b1;
        for (int c = 0; c < budget && !ok; c++) begin
            @(negedge clk);
            if (host_ready === 1'b1) begin
                model_accept(op);
                ok = 1;
            end
            @(posedge clk);
            #1;
        end
        host_valid = 1'b0;
    endtask

    task automatic push(input logic [3:0] op);
        bit ok;
        offer(op, 50, ok);
        if (!ok) chk("accept_timeout", 0, 1);
    endtask

    task automatic drain(input int budget);
        for (int c = 0; c < budget; c++) begin
            if (exp_q.size() == 0) break;
            @(posedge clk);
        end
        repeat (3) @(posedge clk);
        #1;
        chk("drain_empty", exp_q.size(), 0);
    endtask

    task automatic do_reset();
        host_valid = 1'b0;
        done = 1'b0;
        hold_busy = 1'b0;
        auto_ack = 1'b1;
        reset = 1'b1;
        exp_q.delete();
        pulse_cyc.delete();
        drops_m = 0;
        sealed_m = 0;
        first_acc = -1;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_cmd", int'(cmd), 0);
        chk("rst_cmd_valid", int'(cmd_valid), 0);
        chk("rst_seq_done", int'(seq_done), 0);
        chk("rst_drop_cnt", int'(drop_cnt), 0);
        chk("rst_host_ready", int'(host_ready), 1);
        reset = 1'b0;
        @(posedge clk);
        #1;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not complete, expected finish");
        $fatal(1);
    end

    initial begin
        bit         ok;
        logic [3:0] op;

        // Back-to-back SR, SD, MAX, WR with a one-cycle busy answer.
        do_reset();
        push(CMD_SR);
        push(CMD_SD);
        push(CMD_MAX);
        push(CMD_WR);
        drain(50);
        chk("t1_pulses", pulse_cyc.size(), 4);
        if (pulse_cyc.size() == 4) begin
            chk("t1_first_latency", pulse_cyc[0] - first_acc, 2);
            for (int i = 1; i < 4; i++) chk("t1_spacing", pulse_cyc[i] - pulse_cyc[i-1], 3);
            while (cyc < pulse_cyc[3] + 70) begin
                @(posedge clk);
                #1;
            end
        end
        chk("t1_seq_done_before", int'(seq_done), 0);
        done = 1'b1;
        @(posedge clk);
        #1;
        done = 1'b0;
        chk("t1_seq_done_after", int'(seq_done), 1);
        chk("t1_ready_sealed", int'(host_ready), 0);

        // Illegal opcodes dropped; early done ignored.
        do_reset();
        push(4'd13);
        done = 1'b1;
        push(4'd15);
        done = 1'b0;
        push(CMD_AVG);
        drain(30);
        chk("t2_drop_cnt", int'(drop_cnt), drops_m);
        chk("t2_drop_two", drops_m, 2);
        chk("t2_pulses", pulse_cyc.size(), 1);
        chk("t2_seq_done", int'(seq_done), 0);

        // Full FIFO back-pressure while the controller stays busy.
        do_reset();
        hold_busy = 1'b1;
        @(posedge clk);
        #1;
        for (int i = 0; i < int'(DEPTH); i++) begin
            offer(4'($urandom_range(1, 11)), 1, ok);
            chk("t3_fill_accept", int'(ok), 1);
        end
        op = 4'($urandom_range(1, 11));
        host_cmd = op;
        host_valid = 1'b1;
        repeat (5) begin
            @(negedge clk);
            chk("t3_full_ready", int'(host_ready), 0);
        end
        @(posedge clk);
        #1;
        hold_busy = 1'b0;
        push(op);
        chk("t3_ninth_after_issue", int'(pulse_cyc.size() > 0), 1);
        drain(100);
        chk("t3_pulses", pulse_cyc.size(), int'(DEPTH) + 1);

        // WRITE seals the host port.
        do_reset();
        push(CMD_WR);
        host_cmd = CMD_SL;
        host_valid = 1'b1;
        repeat (10) begin
            @(negedge clk);
            chk("t4_sealed_ready", int'(host_ready), 0);
        end
        @(posedge clk);
        #1;
        host_valid = 1'b0;
        drain(20);
        chk("t4_pulses", pulse_cyc.size(), 1);

        // Reset while waiting for an acknowledge with three entries queued.
        do_reset();
        auto_ack = 1'b0;
        push(4'd14);
        push(CMD_SU);
        push(CMD_SD);
        push(CMD_SL);
        push(CMD_SR);
        for (int c = 0; c < 20 && exp_q.size() != 3; c++) @(posedge clk);
        repeat (2) @(posedge clk);
        #1;
        chk("t5_queued", exp_q.size(), 3);
        chk("t5_drop_before", int'(drop_cnt), 1);
        reset = 1'b1;
        #1;
        chk("t5_async_cmd", int'(cmd), 0);
        chk("t5_async_cmd_valid", int'(cmd_valid), 0);
        chk("t5_async_seq_done", int'(seq_done), 0);
        chk("t5_async_drop_cnt", int'(drop_cnt), 0);
        chk("t5_async_ready", int'(host_ready), 1);
        exp_q.delete();
        pulse_cyc.delete();
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
        auto_ack = 1'b1;
        repeat (20) @(posedge clk);
        #1;
        chk("t5_no_issue", pulse_cyc.size(), 0);

        // Drop counter saturation.
        do_reset();
        for (int i = 0; i < 300; i++) begin
            push(4'($urandom_range(12, 15)));
            if (i == 99) chk("t6_drop_100", int'(drop_cnt), drops_m);
        end
        chk("t6_drop_sat", int'(drop_cnt), 255);
        chk("t6_model_sat", drops_m, 255);

        // Randomized mixed traffic.
        for (int r = 0; r < 4; r++) begin
            do_reset();
            for (int i = 0; i < 25; i++) begin
                op = 4'($urandom_range(0, 15));
                if (sealed_m) begin
                    offer(op, 3, ok);
                    chk("t7_sealed_block", int'(ok), 0);
                end else begin
                    push(op);
                end
                repeat ($urandom_range(0, 3)) begin
                    @(posedge clk);
                    #1;
                end
            end
            drain(300);
            chk("t7_drop_cnt", int'(drop_cnt), drops_m);
            done = 1'b1;
            @(posedge clk);
            #1;
            done = 1'b0;
            chk("t7_seq_done", int'(seq_done), sealed_m ? 1 : 0);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
